// File: rtl/packet_limiter_pkg.sv
// Shared definitions for the packet limiter: FSM states and counter widths.
package packet_limiter_pkg;

    localparam int PKT_CNT_W  = 32;
    localparam int BYTE_CNT_W = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN
    } state_t;

endpackage

// File: rtl/packet_limiter_if.sv
// AXI-Stream bundle used for both the input and output side of the limiter.
interface packet_limiter_if #(
    parameter int DW = 512
);

    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );

endinterface

// File: rtl/packet_limiter_keep_popcount.sv
// Purely combinational ones-count of a TKEEP vector (bytes valid in one beat).
module keep_popcount #(
    parameter int KW = 64,
    parameter int CW = $clog2(KW) + 1
) (
    input  logic [KW-1:0] keep,
    output logic [CW-1:0] count
);

    // Sum every keep bit; the width holds the all-ones case without overflow.
    always_comb begin
        count = '0;
        for (int i = 0; i < KW; i++) begin
            count = count + CW'(keep[i]);
        end
    end

endmodule

// File: rtl/packet_limiter.sv
// Forwards a bounded number of whole AXI-Stream packets after a start pulse,
// then closes and drops everything else. Counts forwarded packets and bytes.
module packet_limiter
    import packet_limiter_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [PKT_CNT_W-1:0]  max_packets,
    output logic                  busy,
    output logic                  done,
    output logic [PKT_CNT_W-1:0]  packet_count,
    output logic [BYTE_CNT_W-1:0] byte_count,
    packet_limiter_if.slave       axis_in,
    packet_limiter_if.master      axis_out
);

    localparam int KW = DW / 8;
    localparam int PW = $clog2(KW) + 1;

    state_t                  state;
    state_t                  state_nxt;
    logic                    in_packet;
    logic                    done_r;
    logic [PKT_CNT_W-1:0]    limit;
    logic [PKT_CNT_W-1:0]    pkt_cnt;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic [PW-1:0]           keep_ones;
    logic                    in_hs;
    logic                    out_hs;
    logic                    limit_hit;

    keep_popcount #(
        .KW (KW),
        .CW (PW)
    ) u_keep_popcount (
        .keep  (axis_in.tkeep),
        .count (keep_ones)
    );

    // In RUN the output is the input, so the input side handshake terms
    // describe the output handshake as well.
    assign in_hs     = axis_in.tvalid & axis_in.tready;
    assign out_hs    = (state == S_RUN) & axis_in.tvalid & axis_out.tready;
    assign limit_hit = out_hs & axis_in.tlast & (limit != '0)
                       & ((pkt_cnt + PKT_CNT_W'(1)) == limit);

    assign busy         = (state != S_IDLE);
    assign done         = done_r;
    assign packet_count = pkt_cnt;
    assign byte_count   = byte_cnt;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stream gating; the output bus is forced to zero unless running.
    always_comb begin
        state_nxt       = state;
        axis_in.tready  = 1'b1;
        axis_out.tdata  = '0;
        axis_out.tkeep  = '0;
        axis_out.tlast  = 1'b0;
        axis_out.tvalid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // Drain the tail of a packet already in flight; stall at a
                // boundary so the next packet head is not lost.
                axis_in.tready = in_packet;
                if (!in_packet) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                axis_out.tdata  = axis_in.tdata;
                axis_out.tkeep  = axis_in.tkeep;
                axis_out.tlast  = axis_in.tlast;
                axis_out.tvalid = axis_in.tvalid;
                axis_in.tready  = axis_out.tready;
                if (limit_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Track whether the input stream is between the head and tail of a packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_packet <= 1'b0;
        end else if (in_hs) begin
            in_packet <= !axis_in.tlast;
        end
    end

    // Run setup on start and counting of forwarded beats and packets.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            limit    <= '0;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            done_r   <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            limit    <= max_packets;
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            done_r   <= 1'b0;
        end else if (out_hs) begin
            byte_cnt <= byte_cnt + BYTE_CNT_W'(keep_ones);
            if (axis_in.tlast) begin
                pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
            end
            if (limit_hit) begin
                done_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_limiter.sv
// Directed self-checking bench for packet_limiter.
module tb_packet_limiter;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] max_packets;
    logic        busy;
    logic        done;
    logic [31:0] packet_count;
    logic [63:0] byte_count;

    packet_limiter_if #(.DW(DW)) in_if ();
    packet_limiter_if #(.DW(DW)) out_if ();

    packet_limiter #(.DW(DW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .max_packets  (max_packets),
        .busy         (busy),
        .done         (done),
        .packet_count (packet_count),
        .byte_count   (byte_count),
        .axis_in      (in_if),
        .axis_out     (out_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit bp_en    = 1'b0;
    int cyc      = 0;

    logic [DW-1:0] out_data_q[$];
    logic [KW-1:0] out_keep_q[$];
    bit            out_last_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int id, input int b);
        logic [DW-1:0] d;
        d = '0;
        for (int j = 0; j < DW / 64; j++) begin
            d[j*64 +: 64] = {16'hA5A5, 8'(j), 8'(b), 32'(id)};
        end
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        bit hs;
        int n;
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tlast  = l;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = in_if.tready;
            step();
            n++;
        end
        if (!hs) chk("beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_packet(input int id, input int nb, input logic [KW-1:0] last_keep);
        for (int b = 0; b < nb; b++) begin
            drive_beat(beat_data(id, b), (b == nb - 1) ? last_keep : {KW{1'b1}}, b == nb - 1);
        end
    endtask

    task automatic idle_bus();
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tkeep  = '0;
        in_if.tdata  = '0;
    endtask

    task automatic pulse_start(input logic [31:0] lim);
        max_packets = lim;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic clear_out();
        out_data_q.delete();
        out_keep_q.delete();
        out_last_q.delete();
    endtask

    // Record every output handshake mid-cycle.
    always @(negedge clk) begin
        if (resetn && out_if.tvalid && out_if.tready) begin
            out_data_q.push_back(out_if.tdata);
            out_keep_q.push_back(out_if.tkeep);
            out_last_q.push_back(1'b1 & out_if.tlast);
        end
    end

    // Downstream ready: always ready, or a fixed stall pattern when enabled.
    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            out_if.tready = bp_en ? ((cyc % 3) != 0) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]   exp_bytes;
        logic [KW-1:0] lk;

        resetn      = 1'b0;
        start       = 1'b0;
        max_packets = '0;
        idle_bus();
        step();
        step();

        // Reset state
        chk("rst_in_tready", 64'(in_if.tready), 64'd1);
        chk("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("rst_out_tdata_zero", 64'(out_if.tdata == '0), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pkt", 64'(packet_count), 64'd0);
        chk("rst_bytes", byte_count, 64'd0);
        resetn = 1'b1;
        step();

        // Limit 3, ten back-to-back 4-beat packets
        clear_out();
        pulse_start(32'd3);
        chk("t1_busy_armed", 64'(busy), 64'd1);
        for (int p = 0; p < 10; p++) send_packet(p, 4, {KW{1'b1}});
        idle_bus();
        step();
        chk("t1_out_beats", 64'(out_data_q.size()), 64'd12);
        chk("t1_pkt", 64'(packet_count), 64'd3);
        chk("t1_bytes", byte_count, 64'd768);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        if (out_data_q.size() > 0) chk("t1_first_lo", out_data_q[0][63:0], beat_data(0, 0)[63:0]);

        // start during beat 2 of a packet: tail is dropped
        clear_out();
        drive_beat(beat_data(20, 0), {KW{1'b1}}, 1'b0);
        max_packets = 32'd1;
        start       = 1'b1;
        drive_beat(beat_data(20, 1), {KW{1'b1}}, 1'b0);
        start       = 1'b0;
        drive_beat(beat_data(20, 2), {KW{1'b1}}, 1'b0);
        drive_beat(beat_data(20, 3), {KW{1'b1}}, 1'b1);
        send_packet(21, 4, {KW{1'b1}});
        idle_bus();
        step();
        chk("t2_out_beats", 64'(out_data_q.size()), 64'd4);
        if (out_data_q.size() > 0) chk("t2_first_lo", out_data_q[0][63:0], beat_data(21, 0)[63:0]);
        chk("t2_pkt", 64'(packet_count), 64'd1);
        chk("t2_bytes", byte_count, 64'd256);
        chk("t2_done", 64'(done), 64'd1);

        // Backpressure with limit 2, plus a start while busy
        clear_out();
        bp_en = 1'b1;
        pulse_start(32'd2);
        send_packet(30, 3, {KW{1'b1}});
        chk("t4_pkt_after1", 64'(packet_count), 64'd1);
        chk("t4_done_after1", 64'(done), 64'd0);
        idle_bus();
        pulse_start(32'd5);
        chk("t4_busy_ignored_start", 64'(busy), 64'd1);
        chk("t4_pkt_not_cleared", 64'(packet_count), 64'd1);
        chk("t4_bytes_not_cleared", byte_count, 64'd192);
        send_packet(31, 3, {KW{1'b1}});
        chk("t4_done_next_cycle", 64'(done), 64'd1);
        chk("t4_busy_low", 64'(busy), 64'd0);
        chk("t4_out_gated", 64'(out_if.tvalid), 64'd0);
        chk("t4_pkt", 64'(packet_count), 64'd2);
        chk("t4_bytes", byte_count, 64'd384);
        send_packet(32, 3, {KW{1'b1}});
        idle_bus();
        bp_en = 1'b0;
        step();
        chk("t4_out_beats", 64'(out_data_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < out_data_q.size()) begin
                chk("t4_data_lo", out_data_q[i][63:0], beat_data(30 + i / 3, i % 3)[63:0]);
                chk("t4_data_hi", out_data_q[i][DW-1:DW-64], beat_data(30 + i / 3, i % 3)[DW-1:DW-64]);
                chk("t4_last", 64'(out_last_q[i]), 64'((i % 3) == 2));
            end
        end

        // Unlimited mode, 100 packets with varying last-beat TKEEP
        clear_out();
        exp_bytes = '0;
        pulse_start(32'd0);
        for (int p = 0; p < 100; p++) begin
            lk = {KW{1'b1}} >> (p % 64);
            send_packet(p, 2, lk);
            exp_bytes = exp_bytes + 64'd64 + 64'($countones(lk));
        end
        idle_bus();
        step();
        chk("t3_out_beats", 64'(out_data_q.size()), 64'd200);
        chk("t3_pkt", 64'(packet_count), 64'd100);
        chk("t3_bytes", byte_count, 64'd10154);
        chk("t3_bytes_sb", byte_count, exp_bytes);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_done", 64'(done), 64'd0);
        if (out_keep_q.size() > 1) chk("t3_keep1", 64'($countones(out_keep_q[1])), 64'd64);
        if (out_keep_q.size() > 3) chk("t3_keep3", 64'($countones(out_keep_q[3])), 64'd63);

        // Reset pulsed mid-run, then a clean run from zero
        in_if.tvalid = 1'b1;
        in_if.tdata  = beat_data(50, 0);
        in_if.tkeep  = {KW{1'b1}};
        in_if.tlast  = 1'b0;
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_out_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("t5_out_tdata_zero", 64'(out_if.tdata == '0), 64'd1);
        chk("t5_in_tready", 64'(in_if.tready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_pkt", 64'(packet_count), 64'd0);
        chk("t5_bytes", byte_count, 64'd0);
        idle_bus();
        #2;
        resetn = 1'b1;
        step();
        clear_out();
        pulse_start(32'd1);
        send_packet(60, 2, {KW{1'b1}});
        idle_bus();
        step();
        chk("t5_rerun_pkt", 64'(packet_count), 64'd1);
        chk("t5_rerun_bytes", byte_count, 64'd128);
        chk("t5_rerun_done", 64'(done), 64'd1);
        chk("t5_rerun_beats", 64'(out_data_q.size()), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
